// File: rtl/count_pwm_compare_if.sv
// Bus between the counter-driven PWM comparator and its controller:
// time-base count, duty programming, run request and the PWM status outputs.
interface count_pwm_compare_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Q_in;
    logic [WIDTH-1:0] Duty;
    logic             Load;
    logic             Enable;
    logic             PWM_out;
    logic             Wrap;
    logic             Busy;
    logic [WIDTH-1:0] Periods;

    modport master (
        output Q_in, Duty, Load, Enable,
        input  PWM_out, Wrap, Busy, Periods
    );

    modport slave (
        input  Q_in, Duty, Load, Enable,
        output PWM_out, Wrap, Busy, Periods
    );
endinterface

// File: rtl/count_pwm_compare.sv
// PWM generator timed by an external free-running counter, with double-buffered
// duty, period-aligned start/stop and a saturating completed-period count.
module count_pwm_compare #(
    parameter int WIDTH = 8
) (
    input  logic                CLK,
    input  logic                Clear,
    count_pwm_compare_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    state_t           state_q;
    logic [WIDTH-1:0] prev_q_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] active_q;
    logic [WIDTH-1:0] active_d;
    logic [WIDTH-1:0] periods_q;
    logic             pwm_q;
    logic             wrap_q;
    logic             busy_q;
    logic             wrap_det_s;
    logic             cmp_s;

    // Wrap detection and the duty value in force after this edge (Load bypasses the shadow on a wrap).
    always_comb begin
        wrap_det_s = (prev_q_q == CNT_MAX) && (bus.Q_in == CNT_ZERO);
        active_d   = active_q;
        if (wrap_det_s) begin
            if (bus.Load) begin
                active_d = bus.Duty;
            end else begin
                active_d = shadow_q;
            end
        end else begin
            active_d = active_q;
        end
        cmp_s = (bus.Q_in < active_d);
    end

    // Duty buffers, wrap strobe and the run-control state machine with its registered outputs.
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            state_q   <= ST_IDLE;
            prev_q_q  <= CNT_ZERO;
            shadow_q  <= CNT_ZERO;
            active_q  <= CNT_ZERO;
            periods_q <= CNT_ZERO;
            pwm_q     <= 1'b0;
            wrap_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            prev_q_q <= bus.Q_in;
            wrap_q   <= wrap_det_s;
            active_q <= active_d;
            if (bus.Load) begin
                shadow_q <= bus.Duty;
            end

            case (state_q)
                ST_IDLE: begin
                    pwm_q <= 1'b0;
                    if (bus.Enable) begin
                        state_q <= ST_ARMED;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    pwm_q <= 1'b0;
                    if (!bus.Enable) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (wrap_det_s) begin
                        state_q   <= ST_RUN;
                        periods_q <= CNT_ZERO;
                        busy_q    <= 1'b1;
                    end else begin
                        busy_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    pwm_q  <= cmp_s;
                    busy_q <= 1'b1;
                    if (wrap_det_s && (periods_q != CNT_MAX)) begin
                        periods_q <= periods_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                    if (!bus.Enable) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The period in flight completes; a re-raised Enable resumes without a gap.
                    if (wrap_det_s) begin
                        state_q <= ST_IDLE;
                        pwm_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        pwm_q  <= cmp_s;
                        busy_q <= 1'b1;
                        if (bus.Enable) begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pwm_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PWM_out = pwm_q;
    assign bus.Wrap    = wrap_q;
    assign bus.Busy    = busy_q;
    assign bus.Periods = periods_q;

endmodule

// File: tb/tb_count_pwm_compare.sv
// Scoreboard bench: the stimulus process plays the counter stage, predicts every
// output from a behavioural model and queues it; the monitor compares each cycle.
module tb_count_pwm_compare;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic clk;
    logic clear;

    count_pwm_compare_if #(.WIDTH(8)) bus_if ();

    count_pwm_compare #(.WIDTH(8)) dut (
        .CLK   (clk),
        .Clear (clear),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus state (the emulated counter and control inputs)
    logic [7:0] cnt    = 8'd0;
    logic       cnt_en = 1'b1;
    logic       en     = 1'b0;
    logic       ld     = 1'b0;
    logic [7:0] du     = 8'd0;
    logic       clr    = 1'b1;

    // Behavioural reference
    int m_mode   = M_IDLE;
    int m_prev   = 0;
    int m_shadow = 0;
    int m_active = 0;
    int m_per    = 0;
    int m_pwm    = 0;
    int m_wrap   = 0;

    logic [10:0] sb[$];

    // Measurements taken by the monitor
    int acc_high  = 0;
    int last_high = -1;
    int wrap_seen = 0;
    int cyc       = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  q;
        bit  wd;
        q = int'(cnt);
        if (clr) begin
            m_mode = M_IDLE; m_prev = 0; m_shadow = 0; m_active = 0;
            m_per = 0; m_pwm = 0; m_wrap = 0;
        end else begin
            wd = (m_prev == 255) && (q == 0);
            if (wd) m_active = ld ? int'(du) : m_shadow;
            if (ld) m_shadow = int'(du);
            m_prev = q;
            m_wrap = wd ? 1 : 0;
            if (m_mode == M_IDLE) begin
                m_pwm = 0;
                if (en) m_mode = M_ARMED;
            end else if (m_mode == M_ARMED) begin
                m_pwm = 0;
                if (!en) m_mode = M_IDLE;
                else if (wd) begin m_mode = M_RUN; m_per = 0; end
            end else if (m_mode == M_RUN) begin
                m_pwm = (q < m_active) ? 1 : 0;
                if (wd) m_per = (m_per >= 255) ? 255 : m_per + 1;
                if (!en) m_mode = M_DRAIN;
            end else begin
                if (wd) begin
                    m_mode = M_IDLE;
                    m_pwm  = 0;
                end else begin
                    m_pwm = (q < m_active) ? 1 : 0;
                    if (en) m_mode = M_RUN;
                end
            end
        end
        sb.push_back({m_pwm[0], m_wrap[0], (m_mode != M_IDLE), m_per[7:0]});
    endtask

    task automatic step();
        bus_if.Q_in   = cnt;
        bus_if.Enable = en;
        bus_if.Load   = ld;
        bus_if.Duty   = du;
        clear         = clr;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        ld = 1'b0;
        if (clr) cnt = 8'd0;
        else if (cnt_en) cnt = cnt + 8'd1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_q(input int v);
        int guard;
        guard = 0;
        while ((int'(cnt) != v) && (guard < 300)) begin
            step();
            guard++;
        end
        if (guard >= 300) begin
            checks++;
            errors++;
            $display("FAIL run_until_q: counter never reached %0d", v);
        end
    endtask

    task automatic load_at(input int q, input logic [7:0] d);
        run_until_q(q);
        ld = 1'b1;
        du = d;
        step();
    endtask

    // Monitor: pop one prediction per clock and measure per-period high time.
    always @(posedge clk) begin
        logic [10:0] act;
        logic [10:0] exp;
        #1;
        cyc++;
        act = {bus_if.PWM_out, bus_if.Wrap, bus_if.Busy, bus_if.Periods};
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL outputs cyc %0d q=%0d: got pwm/wrap/busy/per=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                         cyc, bus_if.Q_in, act[10], act[9], act[8], act[7:0],
                         exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
        if (bus_if.Wrap === 1'b1) begin
            wrap_seen++;
            last_high = acc_high;
            acc_high  = (bus_if.PWM_out === 1'b1) ? 1 : 0;
        end else begin
            acc_high += (bus_if.PWM_out === 1'b1) ? 1 : 0;
        end
    end

    int per_hold;
    int w0;

    initial begin
        bus_if.Q_in = 8'd0; bus_if.Duty = 8'd0; bus_if.Load = 1'b0; bus_if.Enable = 1'b0;
        clear = 1'b1;
        @(negedge clk);

        // Reset holds everything at zero despite active inputs
        clr = 1'b1; en = 1'b1; cnt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin ld = 1'b1; du = 8'h80; step(); end
        clr = 1'b0; en = 1'b0; cnt_en = 1'b1;
        run(512);

        // Basic PWM at duty 64
        en = 1'b1;
        load_at(0, 8'd64);
        run_until_q(0);
        run(256 * 3 + 1);
        chk("basic_high", last_high, 64);
        chk("basic_periods", int'(bus_if.Periods), 3);

        // Double buffering: mid-period load waits for the wrap
        load_at(100, 8'd200);
        run_until_q(0); step();
        chk("dbuf_current", last_high, 64);
        run_until_q(0); step();
        chk("dbuf_next", last_high, 200);

        // Load on the wrap cycle takes effect immediately
        load_at(0, 8'd10);
        run_until_q(0); step();
        chk("bypass_high", last_high, 10);

        // Duty boundaries
        load_at(100, 8'd0);
        run_until_q(0); step(); run_until_q(0); step();
        chk("duty0_high", last_high, 0);
        load_at(100, 8'd255);
        run_until_q(0); step(); run_until_q(0); step();
        chk("duty255_high", last_high, 255);

        // Counter held mid-period
        load_at(100, 8'd64);
        run_until_q(0); step();
        run_until_q(50);
        w0 = wrap_seen;
        cnt_en = 1'b0;
        run(20);
        cnt_en = 1'b1;
        chk("hold_pwm", int'(bus_if.PWM_out), 1);
        chk("hold_nowrap", wrap_seen - w0, 0);

        // Stop: period completes, then IDLE with Periods held
        run_until_q(0); step();
        run_until_q(30);
        en = 1'b0;
        per_hold = m_per;
        run_until_q(0); step();
        chk("stop_busy", int'(bus_if.Busy), 0);
        chk("stop_pwm", int'(bus_if.PWM_out), 0);
        chk("stop_periods", int'(bus_if.Periods), per_hold);

        // Restart, then drain and resume without a gap
        en = 1'b1;
        run_until_q(0); step();
        run_until_q(30);
        en = 1'b0;
        run_until_q(200);
        en = 1'b1;
        run_until_q(0); step();
        chk("resume_busy", int'(bus_if.Busy), 1);

        // Saturation
        run(260 * 256);
        chk("sat_periods", int'(bus_if.Periods), 255);

        // Asynchronous clear mid-run
        run_until_q(40);
        clear = 1'b1;
        clr   = 1'b1;
        #1;
        chk("clr_async", int'({bus_if.PWM_out, bus_if.Wrap, bus_if.Busy, bus_if.Periods}), 0);
        run(2);
        clr = 1'b0;
        en  = 1'b0;
        run(5);
        chk("clr_idle_busy", int'(bus_if.Busy), 0);

        @(posedge clk); #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_pwm_compare.md
Name: count_pwm_compare

Overview:
- Downstream consumer of the 8-bit D flip-flop counter; takes its Q bus as the time base and produces a PWM waveform, a period-wrap strobe and a completed-period count.
- Duty is double-buffered: writes go to a shadow register and take effect only on a counter wrap, so no runt or glitched periods occur.
- Start/stop are period-aligned through a small state machine.

Parameters:
- WIDTH, 8, width of count input, duty and period counter (the counter stage is 8 bits; only 8 is verified).

Ports:
- CLK  input  1  rising-edge clock, same clock as the counter stage
- Clear  input  1  asynchronous active-high reset; also drive it into the counter stage's Clear
- Q_in  input  8  count value from the counter stage Q
- Duty  input  8  duty value to write into the shadow register
- Load  input  1  when 1 at a CLK edge, shadow register <= Duty
- Enable  input  1  run request, level sensitive
- PWM_out  output  1  registered PWM output
- Wrap  output  1  one-cycle pulse marking a detected counter wrap
- Busy  output  1  1 in ARMED, RUN or DRAIN states
- Periods  output  8  completed PWM periods since leaving IDLE, saturating at 255

Behaviour:
- Reset (Clear=1, asynchronous, held for as long as Clear is high):
  - state=IDLE; PWM_out=0, Wrap=0, Busy=0, Periods=0.
  - shadow=0, active duty=0, prev_q=0.
- Wrap detection:
  - prev_q <= Q_in every edge.
  - wrap_det = (prev_q==8'hFF && Q_in==8'h00).
  - Wrap is the registered wrap_det, so it is high the cycle after Q_in reads 0.
  - A held counter (count enable=0) never produces wrap_det.
  - Jumps other than FF->00 (for example a counter Clear) are not wraps.
- Shadow/active duty:
  - Load=1 -> shadow <= Duty.
  - On wrap_det, active <= shadow.
  - If Load and wrap_det occur in the same cycle, active <= Duty (bypass) and shadow <= Duty.
- State machine, evaluated each CLK edge:
  - IDLE: PWM_out<=0. Enable=1 -> ARMED.
  - ARMED: PWM_out<=0. wrap_det -> RUN with Periods<=0. Enable=0 -> IDLE.
  - RUN: PWM_out <= (Q_in < active), using the value of active after any same-edge update. wrap_det -> Periods <= Periods+1, saturating at 255. Enable=0 -> DRAIN.
  - DRAIN: PWM output continues as in RUN. wrap_det -> IDLE with PWM_out<=0; Periods is held. Enable=1 before that wrap -> back to RUN with no glitch.
- Latency: PWM_out lags Q_in by one clock. Wrap is likewise one clock after Q_in==00.
- Duty boundaries:
  - Duty 0 -> PWM_out constantly 0 in RUN.
  - Duty 255 -> high for 255 of every 256 counts.
  - Duty N -> high for exactly N counter steps per period, assuming a free-running counter.
- Counter held mid-period: PWM_out stays at its comparison value; no wrap occurs.
- Clear asserted mid-period: immediate return to reset values; after Clear drops, the block starts in IDLE.
- Busy = (state != IDLE), registered along with state.

Test Plan:
- Reset and idle:
  - Stimulus: Clear=1 for 4 clocks with Enable=1, Load=1, Duty=8'h80.
  - Required: all outputs 0 throughout.
  - After Clear=0 with Enable=0 and a free-running counter: PWM_out=0 and Periods=0 for 512 clocks.
- Basic PWM:
  - Stimulus: Load Duty=64, Enable=1, counter free-running from 0.
  - Required: ARMED until the first FF->00; then PWM_out high for 64 clocks and low for 192 clocks each period.
  - Wrap pulses every 256 clocks; Periods=3 after 3 further wraps.
- Double buffering:
  - Stimulus: in RUN with Duty=64, Load Duty=200 when Q_in=100.
  - Required: the current period keeps a 64-clock high time; the next period has a 200-clock high time.
  - Stimulus: Load exactly on the wrap cycle with Duty=10.
  - Required: that period already has a 10-clock high time.
- Boundaries:
  - Duty=0 -> PWM_out never high.
  - Duty=255 -> high 255 and low 1 per period.
  - Counter held at Q=50 for 20 clocks with Duty=64 -> PWM_out stays 1 and no Wrap.
- Stop/restart:
  - Stimulus: Enable=0 at Q_in=30.
  - Required: the period completes; IDLE is entered after FF->00 with PWM_out=0 and Busy=0; Periods is held.
  - Stimulus: Enable re-raised at Q_in=200 while in DRAIN.
  - Required: stays running, no PWM gap.
- Saturation and mid-run reset:
  - Stimulus: run 260 periods.
  - Required: Periods=255.
  - Stimulus: pulse Clear at Q_in=40.
  - Required: outputs 0 immediately and state=IDLE.
